hour_keeper_fmt: RTL and testbench

//  Hour-of-day counter with selectable 12/24 h display. Successor to the plain 24->12 h converter.

---
 rtl/clock_pkg.sv | 24 ++
 rtl/hour_fmt_conv.sv | 14 +
 rtl/hour_keeper_fmt.sv | 87 ++++++++
 tb/tb_hour_keeper_fmt.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// clock_pkg: shared hour-counter constants, state type and formatting helpers
package clock_pkg;
    localparam int HOUR_W        = 5;
    localparam int HOURS_PER_DAY = 24;
    localparam int NOON          = 12;

    typedef enum logic {ST_RUN, ST_SET} state_t;

    // two BCD digits for a binary value in 0..23
    function automatic logic [7:0] bin2bcd8(input logic [HOUR_W-1:0] b);
        logic [3:0] t;
        logic [HOUR_W-1:0] u;
        t = (b >= 5'd20) ? 4'd2 : (b >= 5'd10) ? 4'd1 : 4'd0;
        u = b - ((b >= 5'd20) ? 5'd20 : (b >= 5'd10) ? 5'd10 : 5'd0);
        return {t, u[3:0]};
    endfunction

    // display value for a 24 h hour in either display mode and output coding
    function automatic logic [7:0] fmt_hour(input logic [HOUR_W-1:0] h, input logic m12, input logic bcd);
        logic [HOUR_W-1:0] v;
        v = !m12 ? h : (h == 5'd0) ? 5'(NOON) : (h > 5'(NOON)) ? h - 5'(NOON) : h;
        return bcd ? bin2bcd8(v) : {3'b000, v};
    endfunction
endpackage

// File: rtl/hour_fmt_conv.sv
// hour_fmt_conv: combinational 24 h hour to display value and AM/PM flag
module hour_fmt_conv
    import clock_pkg::*;
#(
    parameter int OUT_BCD = 0
) (
    input  logic [HOUR_W-1:0] h,
    input  logic              mode12,
    output logic [7:0]        disp,
    output logic              nAM_PM
);
    assign disp   = fmt_hour(h, mode12, OUT_BCD != 0);
    assign nAM_PM = h > 5'(NOON - 1);
endmodule

// File: rtl/hour_keeper_fmt.sv
// hour_keeper_fmt: hour-of-day counter with RUN/SET control and registered 12/24 h display
module hour_keeper_fmt
    import clock_pkg::*;
#(
    parameter int OUT_BCD    = 0,
    parameter int RESET_HOUR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              mode12,
    input  logic              set_en,
    input  logic              inc,
    input  logic              dec,
    input  logic              load,
    input  logic [HOUR_W-1:0] load_hour,
    output logic [HOUR_W-1:0] hour24,
    output logic [7:0]        hour_disp,
    output logic              nAM_PM,
    output logic              day_tick,
    output logic              load_err,
    output logic              set_active
);
    localparam logic [HOUR_W-1:0] RST_H    = HOUR_W'(RESET_HOUR);
    localparam logic [7:0]        RST_D12  = fmt_hour(RST_H, 1'b1, OUT_BCD != 0);
    localparam logic [7:0]        RST_D24  = fmt_hour(RST_H, 1'b0, OUT_BCD != 0);
    localparam logic              RST_PM   = RST_H > 5'(NOON - 1);
    localparam logic [HOUR_W-1:0] LAST_H   = HOUR_W'(HOURS_PER_DAY - 1);

    state_t            r_state;
    logic [HOUR_W-1:0] r_hour;
    logic [7:0]        r_disp;
    logic              r_pm;
    logic              r_day;
    logic              r_err;
    logic [HOUR_W-1:0] w_up;
    logic [HOUR_W-1:0] w_dn;
    logic [HOUR_W-1:0] w_nxt;
    logic [7:0]        w_disp;
    logic              w_pm;
    logic              w_load_ok;
    logic              w_wrap;

    // next hour by priority: load, rejected load, SET stepping, RUN tick
    always_comb begin
        w_up      = (r_hour == LAST_H) ? '0 : r_hour + 5'd1;
        w_dn      = (r_hour == '0) ? LAST_H : r_hour - 5'd1;
        w_load_ok = load_hour <= LAST_H;
        w_wrap    = !load && r_state == ST_RUN && tick && r_hour == LAST_H;
        w_nxt     = load ? (w_load_ok ? load_hour : r_hour)
                  : (r_state == ST_SET) ? ((inc && !dec) ? w_up : (dec && !inc) ? w_dn : r_hour)
                  : tick ? w_up : r_hour;
    end

    hour_fmt_conv #(.OUT_BCD(OUT_BCD)) u_conv (
        .h      (w_nxt),
        .mode12 (mode12),
        .disp   (w_disp),
        .nAM_PM (w_pm)
    );

    // state, hour, formatted display and single-cycle pulses all update together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_hour  <= RST_H;
            r_disp  <= mode12 ? RST_D12 : RST_D24;
            r_pm    <= RST_PM;
            r_day   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= set_en ? ST_SET : ST_RUN;
            r_hour  <= w_nxt;
            r_disp  <= w_disp;
            r_pm    <= w_pm;
            r_day   <= w_wrap;
            r_err   <= load && !w_load_ok;
        end
    end

    assign hour24     = r_hour;
    assign hour_disp  = r_disp;
    assign nAM_PM     = r_pm;
    assign day_tick   = r_day;
    assign load_err   = r_err;
    assign set_active = r_state == ST_SET;
endmodule

// File: tb/tb_hour_keeper_fmt.sv
// tb_hour_keeper_fmt: directed and random checks of hour_keeper_fmt against an arithmetic model
module tb_hour_keeper_fmt;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0, mode12 = 1'b1, set_en = 1'b0, inc = 1'b0, dec = 1'b0, load = 1'b0;
    logic [4:0] load_hour = 5'd0;
    logic [4:0] h_a, h_b;
    logic [7:0] d_a, d_b;
    logic       pm_a, pm_b, dt_a, dt_b, le_a, le_b, sa_a, sa_b;

    int  n_cmp = 0;
    int  n_bad = 0;
    bit  go = 1'b0;
    int  m_hour;
    bit  m_set, m_day, m_err, m_mode;

    always #5 clk = ~clk;

    hour_keeper_fmt #(.OUT_BCD(0), .RESET_HOUR(0)) dut_a (
        .clk(clk), .rst(rst), .tick(tick), .mode12(mode12), .set_en(set_en), .inc(inc), .dec(dec),
        .load(load), .load_hour(load_hour), .hour24(h_a), .hour_disp(d_a), .nAM_PM(pm_a),
        .day_tick(dt_a), .load_err(le_a), .set_active(sa_a));

    hour_keeper_fmt #(.OUT_BCD(1), .RESET_HOUR(0)) dut_b (
        .clk(clk), .rst(rst), .tick(tick), .mode12(mode12), .set_en(set_en), .inc(inc), .dec(dec),
        .load(load), .load_hour(load_hour), .hour24(h_b), .hour_disp(d_b), .nAM_PM(pm_b),
        .day_tick(dt_b), .load_err(le_b), .set_active(sa_b));

    function automatic int efmt(int h, bit m12, bit bcd);
        int v;
        v = !m12 ? h : (h % 12 == 0) ? 12 : h % 12;
        return bcd ? (v / 10) * 16 + v % 10 : v;
    endfunction

    task automatic check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d (0x%0h) expected %0d (0x%0h)", name, $time, act, act, exp, exp);
        end
    endtask

    // reference model: the hour of day as plain modular arithmetic
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_hour = 0; m_set = 0; m_day = 0; m_err = 0; m_mode = mode12;
        end else begin
            m_day = 0; m_err = 0;
            if (load) begin
                if (load_hour < 24) m_hour = load_hour; else m_err = 1;
            end else if (m_set) begin
                if (inc && !dec) m_hour = (m_hour + 1) % 24;
                else if (dec && !inc) m_hour = (m_hour + 23) % 24;
            end else if (tick) begin
                m_day = (m_hour == 23);
                m_hour = (m_hour + 1) % 24;
            end
            m_mode = mode12;
            m_set = set_en;
        end
    end

    // every-cycle comparison of both instances with the model
    always @(negedge clk) if (go) begin
        check("hour24_a", h_a, m_hour);
        check("hour24_b", h_b, m_hour);
        check("disp_bin", d_a, efmt(m_hour, m_mode, 0));
        check("disp_bcd", d_b, efmt(m_hour, m_mode, 1));
        check("nAM_PM", {pm_a, pm_b}, m_hour > 11 ? 3 : 0);
        check("day_tick", {dt_a, dt_b}, m_day ? 3 : 0);
        check("load_err", {le_a, le_b}, m_err ? 3 : 0);
        check("set_active", {sa_a, sa_b}, m_set ? 3 : 0);
    end

    task automatic step(bit t, bit i, bit d, bit l, int lh);
        tick = t; inc = i; dec = d; load = l; load_hour = 5'(lh);
        @(posedge clk);
        #1;
        tick = 0; inc = 0; dec = 0; load = 0;
    endtask

    initial begin
        #1 rst = 1'b1;
        go = 1'b1;
        #13;
        check("rst_hour", h_b, 0);
        check("rst_disp_bcd12", d_b, 8'h12);
        check("rst_disp_bin12", d_a, 12);
        check("rst_pm", pm_b, 0);
        check("rst_day", dt_b, 0);
        @(posedge clk); #2 rst = 1'b0;
        step(0, 0, 0, 1, 11);
        step(1, 0, 0, 0, 0);
        check("t2_hour", h_b, 12);
        check("t2_disp", d_b, 8'h12);
        check("t2_pm", pm_b, 1);
        repeat (11) step(1, 0, 0, 0, 0);
        check("t2_23_12h", d_b, 8'h11);
        mode12 = 1'b0;
        step(0, 0, 0, 0, 0);
        check("t2_23_24h", d_b, 8'h23);
        step(1, 0, 0, 0, 0);
        check("t3_wrap_hour", h_a, 0);
        check("t3_wrap_day", dt_a, 1);
        step(0, 0, 0, 0, 0);
        check("t3_day_clear", dt_a, 0);
        set_en = 1'b1;
        step(0, 0, 0, 1, 23);
        step(0, 1, 0, 0, 0);
        check("t3_set_inc_hour", h_a, 0);
        check("t3_set_inc_day", dt_a, 0);
        step(0, 0, 1, 0, 0);
        check("t4_dec", h_a, 23);
        step(0, 1, 1, 0, 0);
        check("t4_incdec", h_a, 23);
        step(1, 0, 0, 0, 0);
        check("t4_tick_dropped", h_a, 23);
        set_en = 1'b0;
        step(0, 0, 0, 0, 0);
        check("t4_run", sa_a, 0);
        step(1, 0, 0, 0, 0);
        check("t4_run_tick", h_a, 0);
        mode12 = 1'b1;
        step(1, 0, 0, 1, 17);
        check("t5_load_hour", h_a, 17);
        check("t5_load_disp", d_a, 5);
        check("t5_load_pm", pm_a, 1);
        step(1, 0, 0, 1, 25);
        check("t5_bad_hour", h_a, 17);
        check("t5_bad_err", le_a, 1);
        step(0, 0, 0, 0, 0);
        check("t5_err_clear", le_a, 0);
        set_en = 1'b1;
        step(0, 0, 0, 1, 9);
        step(0, 0, 0, 0, 0);
        check("t6_pre_set", sa_a, 1);
        #2 rst = 1'b1;
        #1;
        check("t6_async_hour", h_a, 0);
        check("t6_async_set", sa_a, 0);
        set_en = 1'b0;
        @(posedge clk); #2 rst = 1'b0;
        step(0, 0, 0, 1, 15);
        check("t6_disp12", d_a, 3);
        mode12 = 1'b0;
        check("t6_disp_hold", d_a, 3);
        step(0, 0, 0, 0, 0);
        check("t6_disp24", d_a, 15);
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(299) == 0) begin
                #2 rst = 1'b1;
                @(posedge clk); #2 rst = 1'b0;
            end
            if ($urandom_range(15) == 0) set_en = ~set_en;
            if ($urandom_range(19) == 0) mode12 = ~mode12;
            step($urandom_range(2) == 0, $urandom_range(3) == 0, $urandom_range(3) == 0,
                 $urandom_range(11) == 0, int'($urandom_range(31)));
        end
        @(negedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
